// File: rtl/tt_ovi_issue_queue.sv
// Speculative issue queue between the OVI issue/dispatch port and the VPU.
// Senior entries drain to the VPU; speculative entries await next_senior or kill.
module tt_ovi_issue_queue #(
   parameter int DEPTH     = 8,
   parameter int PAYLOAD_W = 137,
   parameter int SBID_W    = 5,
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 issue_valid,
   input  logic [SBID_W-1:0]    issue_sb_id,
   input  logic [PAYLOAD_W-1:0] issue_payload,
   input  logic                 dispatch_next_senior,
   input  logic                 dispatch_kill,
   input  logic [SBID_W-1:0]    dispatch_sb_id,
   output logic                 read_valid,
   input  logic                 read_ready,
   output logic [SBID_W-1:0]    read_sb_id,
   output logic [PAYLOAD_W-1:0] read_payload,
   output logic [CW-1:0]        issue_credit_cnt,
   output logic [CW-1:0]        occupancy,
   output logic [CW-1:0]        senior_cnt,
   output logic                 err_overflow,
   output logic                 err_dispatch
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]     rd_ptr_q;
   logic [PTR_W-1:0]     disp_ptr_q;
   logic [PTR_W-1:0]     wr_ptr_q;
   logic [CW-1:0]        occ_q;
   logic [CW-1:0]        sen_q;
   logic [CW-1:0]        cred_q;
   logic                 err_ovf_q;
   logic                 err_disp_q;

   logic [SBID_W-1:0]    sb_mem [DEPTH];
   logic [PAYLOAD_W-1:0] pl_mem [DEPTH];

   logic [CW-1:0]        spec_cnt;
   logic [CW-1:0]        killed;
   logic                 full;
   logic                 enq;
   logic                 pop;
   logic                 ns;
   logic                 kill_eff;
   logic                 disp_err;
   logic [SBID_W-1:0]    tgt_sb;

   assign read_valid       = (sen_q != '0);
   assign read_sb_id       = sb_mem[rd_ptr_q];
   assign read_payload     = pl_mem[rd_ptr_q];
   assign issue_credit_cnt = cred_q;
   assign occupancy        = occ_q;
   assign senior_cnt       = sen_q;
   assign err_overflow     = err_ovf_q;
   assign err_dispatch     = err_disp_q;

   // Decode this cycle's enqueue, pop, promotion and kill
   always_comb begin
      spec_cnt = occ_q - sen_q;
      full     = (occ_q == CW'(DEPTH));
      enq      = issue_valid && !full;
      pop      = read_valid && read_ready;
      ns       = 1'b0;
      kill_eff = 1'b0;
      killed   = '0;
      disp_err = 1'b0;
      tgt_sb   = sb_mem[disp_ptr_q];
      if (dispatch_next_senior) begin
         if (spec_cnt != '0) begin
            ns = 1'b1;
         end else if (enq) begin
            ns     = 1'b1;
            tgt_sb = issue_sb_id;
         end
         disp_err = dispatch_kill || !ns ||
                    (tgt_sb != dispatch_sb_id);
      end else if (dispatch_kill) begin
         kill_eff = 1'b1;
         killed   = spec_cnt + CW'(enq);
      end
   end

   // Entry storage; a killed same-cycle write is harmless
   always_ff @(posedge clk) begin
      if (enq) begin
         sb_mem[wr_ptr_q] <= issue_sb_id;
         pl_mem[wr_ptr_q] <= issue_payload;
      end
   end

   // Pointers, counters, credits and sticky errors
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q   <= '0;
         disp_ptr_q <= '0;
         wr_ptr_q   <= '0;
         occ_q      <= '0;
         sen_q      <= '0;
         cred_q     <= '0;
         err_ovf_q  <= 1'b0;
         err_disp_q <= 1'b0;
      end else begin
         if (pop)
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (ns)
            disp_ptr_q <= disp_ptr_q + PTR_W'(1);
         if (kill_eff)
            wr_ptr_q <= disp_ptr_q;
         else if (enq)
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         occ_q  <= occ_q + CW'(enq) - CW'(pop) - killed;
         sen_q  <= sen_q + CW'(ns) - CW'(pop);
         cred_q <= CW'(pop) + killed;
         if (issue_valid && full)
            err_ovf_q <= 1'b1;
         if (disp_err)
            err_disp_q <= 1'b1;
      end
   end

endmodule
